// File: rtl/mem_initiator.sv
// mem_initiator: 2-deep command FIFO feeding a single-outstanding memory access FSM with handshake checking
module mem_initiator #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Cmd_valid,
    output logic              Cmd_ready,
    input  logic              Cmd_wr,
    input  logic [ADDR_W-1:0] Cmd_addr,
    input  logic [DATA_W-1:0] Cmd_wdata,
    output logic              Rsp_valid,
    input  logic              Rsp_ready,
    output logic [DATA_W-1:0] Rsp_data,
    output logic              Rsp_err,
    output logic              En,
    output logic              Rr_en,
    output logic              Rw_en,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] Data_out,
    input  logic              Valid_out,
    output logic [7:0]        Err_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;
    state_t state, state_nx;
    logic [1:0] count;
    logic wptr, rptr, push, pop, cmd_wr, chk_err;
    logic f_wr [2];
    logic [ADDR_W-1:0] f_addr [2];
    logic [DATA_W-1:0] f_wdata [2];
    assign Cmd_ready = count != 2'd2;
    assign push = Cmd_valid && Cmd_ready;
    // case inequality so an undriven (X) Valid_out is flagged as a failure
    assign chk_err = cmd_wr ? (Valid_out !== 1'b0) : (Valid_out !== 1'b1);
    always_comb begin
        state_nx = state;
        pop = 1'b0;
        En = 1'b0;
        Rr_en = 1'b0;
        Rw_en = 1'b0;
        Rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                pop = count != 2'd0;
                state_nx = pop ? ISSUE : IDLE;
            end
            ISSUE: begin
                En = 1'b1;
                Rr_en = !cmd_wr;
                Rw_en = cmd_wr;
                state_nx = CHECK;
            end
            CHECK: state_nx = RESP;
            RESP: begin
                Rsp_valid = 1'b1;
                state_nx = Rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) begin
            f_wr[wptr] <= Cmd_wr;
            f_addr[wptr] <= Cmd_addr;
            f_wdata[wptr] <= Cmd_wdata;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= 2'd0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            cmd_wr <= 1'b0;
            Address <= '0;
            Data_in <= '0;
            Rsp_data <= '0;
            Rsp_err <= 1'b0;
            Err_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            count <= count + {1'b0, push} - {1'b0, pop};
            wptr <= wptr ^ push;
            rptr <= rptr ^ pop;
            if (pop) begin
                cmd_wr <= f_wr[rptr];
                Address <= f_addr[rptr];
                Data_in <= f_wdata[rptr];
            end
            if (state == CHECK) begin
                Rsp_data <= cmd_wr ? '0 : Data_out;
                Rsp_err <= chk_err;
                if (chk_err && Err_cnt != 8'hff) Err_cnt <= Err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: transaction-level model of the initiator plus a simple memory responder with fault injection
module tb_mem_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Cmd_valid = 1'b0, Cmd_wr = 1'b0, Rsp_ready = 1'b0, Valid_out = 1'b0;
    logic [3:0] Cmd_addr = 4'd0;
    logic [31:0] Cmd_wdata = 32'd0, Data_out = 32'd0;
    logic Cmd_ready, Rsp_valid, Rsp_err, En, Rr_en, Rw_en;
    logic [31:0] Rsp_data, Data_in;
    logic [3:0] Address;
    logic [7:0] Err_cnt;
    always #5 clk = ~clk;
    mem_initiator #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_wr(Cmd_wr),
        .Cmd_addr(Cmd_addr), .Cmd_wdata(Cmd_wdata), .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready),
        .Rsp_data(Rsp_data), .Rsp_err(Rsp_err), .En(En), .Rr_en(Rr_en), .Rw_en(Rw_en),
        .Address(Address), .Data_in(Data_in), .Data_out(Data_out), .Valid_out(Valid_out), .Err_cnt(Err_cnt)
    );
    typedef struct {
        logic wr;
        logic [3:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic exp_err;
    } cmd_t;
    cmd_t q[$];
    cmd_t cur, nc;
    bit busy;
    int age, exp_errcnt, sz, en_cnt, rv_cnt;
    int checks = 0, errors = 0;
    logic fault = 1'b0;
    logic exp_en;
    logic [31:0] mm [16];
    logic [31:0] mem [16];
    logic [32:0] rsp_log[$];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // memory responder: acts on the ISSUE pulse, results visible during the following cycle
    always @(negedge clk) begin
        if (En) begin
            if (Rw_en) begin
                mem[Address] = Data_in;
                Valid_out = fault;
            end else begin
                Data_out = mem[Address];
                Valid_out = !fault;
            end
        end
    end
    // per-cycle compare against the model, then advance the model across the next posedge
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ctrl", {En, Rr_en, Rw_en, Rsp_valid, Rsp_err}, 0);
            chk("rst_regs", {Address, Data_in, Rsp_data, Err_cnt}, 0);
            chk("rst_ready", Cmd_ready, 1);
            q.delete();
            busy = 0;
            age = 0;
            exp_errcnt = 0;
        end else begin
            exp_en = busy && age == 1;
            chk("cmd_ready", Cmd_ready, q.size() < 2);
            chk("en", En, exp_en);
            chk("rr_en", Rr_en, exp_en && !cur.wr);
            chk("rw_en", Rw_en, exp_en && cur.wr);
            chk("rsp_valid", Rsp_valid, busy && age >= 3);
            chk("err_cnt", Err_cnt, exp_errcnt);
            if (busy && age <= 2) begin
                chk("address", Address, cur.addr);
                chk("data_in", Data_in, cur.wdata);
            end
            if (busy && age >= 3) begin
                chk("rsp_data", Rsp_data, cur.exp_data);
                chk("rsp_err", Rsp_err, cur.exp_err);
            end
            if (En) en_cnt++;
            if (Rsp_valid) rv_cnt++;
            if (Rsp_valid && Rsp_ready) rsp_log.push_back({Rsp_err, Rsp_data});
            sz = q.size();
            if (busy) begin
                if (age >= 3 && Rsp_ready) busy = 0;
                else begin
                    if (age == 2 && cur.exp_err && exp_errcnt < 255) exp_errcnt++;
                    age++;
                end
            end else if (sz > 0) begin
                cur = q.pop_front();
                cur.exp_data = cur.wr ? 32'd0 : mm[cur.addr];
                cur.exp_err = fault;
                if (cur.wr) mm[cur.addr] = cur.wdata;
                busy = 1;
                age = 1;
            end
            if (Cmd_valid && sz < 2) begin
                nc.wr = Cmd_wr;
                nc.addr = Cmd_addr;
                nc.wdata = Cmd_wdata;
                nc.exp_data = 32'd0;
                nc.exp_err = 1'b0;
                q.push_back(nc);
            end
        end
    end
    task automatic send(input logic wr, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        Cmd_valid = 1'b1;
        Cmd_wr = wr;
        Cmd_addr = a;
        Cmd_wdata = d;
        @(negedge clk);
        while (!Cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", n < 200, 1);
        @(posedge clk);
        #1 Cmd_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 500, 1);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int e0, n0, k;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h1000_0000 + i;
            mm[i] = 32'h1000_0000 + i;
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", Cmd_ready, 1);
        chk("reset_outs", {Rsp_valid, En, Address, Data_in, Rsp_data, Err_cnt}, 0);
        rst = 1'b1;
        Rsp_ready = 1'b1;
        send(1'b1, 4'd3, 32'hDEADBEEF);
        send(1'b0, 4'd3, 32'd0);
        wait_idle();
        chk("wr_rd_count", rsp_log.size(), 2);
        chk("wr_rsp", rsp_log[0], {1'b0, 32'h0});
        chk("rd_rsp", rsp_log[1], {1'b0, 32'hDEADBEEF});
        e0 = en_cnt;
        n0 = rsp_log.size();
        send(1'b0, 4'd3, 32'd0);
        send(1'b1, 4'd5, 32'h12345678);
        send(1'b0, 4'd5, 32'd0);
        wait_idle();
        chk("b2b_en_pulses", en_cnt - e0, 3);
        chk("b2b_rsp0", rsp_log[n0], {1'b0, 32'hDEADBEEF});
        chk("b2b_rsp1", rsp_log[n0 + 1], {1'b0, 32'h0});
        chk("b2b_rsp2", rsp_log[n0 + 2], {1'b0, 32'h12345678});
        Rsp_ready = 1'b0;
        e0 = en_cnt;
        n0 = rsp_log.size();
        send(1'b0, 4'd3, 32'd0);
        send(1'b1, 4'd7, 32'hA5A5A5A5);
        send(1'b0, 4'd7, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_ready", Cmd_ready, 0);
        chk("bp_valid", Rsp_valid, 1);
        chk("bp_data", Rsp_data, 32'hDEADBEEF);
        chk("bp_en_pulses", en_cnt - e0, 1);
        Rsp_ready = 1'b1;
        wait_idle();
        chk("bp_rsp2", rsp_log[n0 + 2], {1'b0, 32'hA5A5A5A5});
        fault = 1'b1;
        send(1'b0, 4'd2, 32'd0);
        wait_idle();
        chk("fault_rsp", rsp_log[rsp_log.size() - 1], {1'b1, 32'h1000_0002});
        chk("fault_cnt1", Err_cnt, 1);
        for (int i = 1; i < 255; i++) begin
            k = i;
            send(k[0], k[3:0], k);
        end
        wait_idle();
        chk("fault_cnt255", Err_cnt, 255);
        send(1'b1, 4'd9, 32'h0BAD0BAD);
        wait_idle();
        chk("fault_sat", Err_cnt, 255);
        fault = 1'b0;
        send(1'b0, 4'd1, 32'd0);
        send(1'b1, 4'd4, 32'h55AA55AA);
        k = 0;
        while (!En && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_en_timeout", k < 20, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_ctrl", {En, Rr_en, Rw_en, Rsp_valid, Rsp_err}, 0);
        chk("mid_regs", {Address, Data_in, Rsp_data, Err_cnt}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        rv_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_rsp", rv_cnt, 0);
        chk("mid_ready", Cmd_ready, 1);
        n0 = rsp_log.size();
        send(1'b0, 4'd9, 32'd0);
        wait_idle();
        chk("post_rst_rd", rsp_log[n0], {1'b0, 32'h0BAD0BAD});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
